// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and multi-cycle op sequencing with watchdog and perf counters
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_op,
  input  logic             mc_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(MC_TIMEOUT + 1);
  typedef enum logic {RUN, MC_WAIT} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use, flush_evt, timeout_evt;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
  // Mealy decode of pipeline controls and next state; reset forces a free-running pipeline
  always_comb begin
    load_use = id_ex_mem_read && id_ex_rd != 5'd0 &&
               ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    state_d = state_q;
    wait_d = wait_q;
    flush_evt = 1'b0;
    timeout_evt = 1'b0;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_start = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_evt = 1'b1;
      end else if (ex_mc_op) begin
        mc_start = 1'b1;
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        ex_mem_bubble = 1'b1;
        state_d = MC_WAIT;
        wait_d = WW'(1);
      end else if (load_use) begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end else begin
      if (mc_ready) begin
        state_d = RUN;
        wait_d = '0;
      end else if (wait_q == WW'(MC_TIMEOUT)) begin
        ex_mem_bubble = 1'b1;
        timeout_evt = 1'b1;
        state_d = RUN;
        wait_d = '0;
      end else begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        ex_mem_bubble = 1'b1;
        wait_d = wait_q + 1'b1;
      end
    end
  end
  // State, wait counter, sticky watchdog flag and saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q <= '0;
      mc_timeout <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      mc_timeout <= mc_timeout | timeout_evt;
      if (!pc_write && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush_evt && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven single-cycle vectors plus multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       mr, u1, u2, br, mc, rdy;
  logic [4:0] rd, rs1, rs2;
  logic       pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, mc_start, mc_timeout;
  logic [1:0] stall_count, flush_count;
  logic [6:0] outs;
  int         n_pass = 0, n_tot = 0;

  hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_use_rs1(u1), .if_id_use_rs2(u2), .ex_branch_taken(br), .ex_mc_op(mc), .mc_ready(rdy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .mc_start(mc_start), .mc_timeout(mc_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign outs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, mc_start};

  localparam logic [6:0] O_RUN = 7'b1110000, O_LU = 7'b0010100, O_BR = 7'b1111100,
                         O_MC = 7'b0000011, O_WAIT = 7'b0000010, O_TO = 7'b1110010;

  typedef struct {
    logic mr; logic [4:0] rd, rs1, rs2; logic u1, u2, br, mc, rdy;
    logic [6:0] out; logic [1:0] sc, fc;
  } vec_t;
  vec_t v[11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(logic a_mr, logic [4:0] a_rd, logic [4:0] a_rs1, logic [4:0] a_rs2,
                       logic a_u1, logic a_u2, logic a_br, logic a_mc, logic a_rdy);
    mr = a_mr; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2; br = a_br; mc = a_mc; rdy = a_rdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic step(string nm, logic [6:0] exp);
    #1 chk(nm, outs, exp);
    tick();
  endtask

  initial begin
    v[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 0};
    v[1]  = '{1, 5, 3, 5, 1, 1, 0, 0, 0, O_LU,  1, 0};
    v[2]  = '{1, 7, 7, 2, 1, 0, 0, 0, 0, O_LU,  1, 0};
    v[3]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, O_RUN, 0, 0};
    v[4]  = '{1, 5, 3, 5, 1, 0, 0, 0, 0, O_RUN, 0, 0};
    v[5]  = '{0, 5, 5, 5, 1, 1, 0, 0, 0, O_RUN, 0, 0};
    v[6]  = '{1, 5, 3, 5, 1, 1, 1, 0, 0, O_BR,  0, 1};
    v[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR,  0, 1};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_MC,  1, 0};
    v[9]  = '{1, 5, 5, 0, 1, 0, 0, 1, 0, O_MC,  1, 0};
    v[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN, 0, 0};

    rst = 1'b1;
    drive(1, 5, 5, 5, 1, 1, 1, 1, 1);
    #1 chk("rst_outputs", outs, O_RUN);
    tick();
    chk("rst_outputs_after_edge", outs, O_RUN);
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_timeout", mc_timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(v[i].mr, v[i].rd, v[i].rs1, v[i].rs2, v[i].u1, v[i].u2, v[i].br, v[i].mc, v[i].rdy);
      #1 chk($sformatf("vec%0d_out", i), outs, v[i].out);
      tick();
      chk($sformatf("vec%0d_stall", i), stall_count, v[i].sc);
      chk($sformatf("vec%0d_flush", i), flush_count, v[i].fc);
    end

    do_reset();
    drive(1, 5, 1, 5, 0, 1, 0, 0, 0);
    step("lu_stall", O_LU);
    idle();
    step("lu_release", O_RUN);
    chk("lu_stall_count", stall_count, 1);

    begin
      int starts = 0, stalled = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
        drive(1, 5, 5, 5, 1, 1, c == 1, 1, c == 3);
        #1 chk($sformatf("mc_c%0d", c), outs, c == 0 ? O_MC : c == 3 ? O_RUN : O_WAIT);
        starts += int'(mc_start);
        stalled += int'(!pc_write);
        tick();
      end
      chk("mc_start_pulses", starts, 1);
      chk("mc_stalled_cycles", stalled, 3);
      chk("mc_stall_count", stall_count, 3);
      chk("mc_flush_ignored", flush_count, 0);
      idle();
      step("mc_back_in_run", O_RUN);
      chk("mc_no_timeout", mc_timeout, 0);
    end

    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wd_start", O_MC);
    for (int c = 1; c <= 3; c++) step($sformatf("wd_wait%0d", c), O_WAIT);
    chk("wd_flag_low_before", mc_timeout, 0);
    step("wd_release", O_TO);
    chk("wd_flag_set", mc_timeout, 1);
    idle();
    step("wd_run1", O_RUN);
    step("wd_run2", O_RUN);
    chk("wd_flag_sticky", mc_timeout, 1);
    chk("wd_stall_saturated", stall_count, 3);

    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wr_start", O_MC);
    for (int c = 1; c <= 3; c++) step($sformatf("wr_wait%0d", c), O_WAIT);
    rdy = 1'b1;
    step("wr_ready_at_limit", O_RUN);
    chk("wr_no_timeout", mc_timeout, 0);
    idle();
    step("wr_run", O_RUN);

    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("ra_start", O_MC);
    step("ra_wait1", O_WAIT);
    rst = 1'b1;
    step("ra_rst_forced", O_RUN);
    rst = 1'b0;
    chk("ra_stall_cleared", stall_count, 0);
    idle();
    step("ra_run_after", O_RUN);
    chk("ra_stall_still0", stall_count, 0);
    mc = 1'b1;
    step("ra_restart", O_MC);

    do_reset();
    drive(1, 9, 9, 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) step($sformatf("sat_lu%0d", c), O_LU);
    chk("sat_stall", stall_count, 3);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 5; c++) step($sformatf("sat_br%0d", c), O_BR);
    chk("sat_flush", flush_count, 3);
    chk("sat_stall_held", stall_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
